// File: rtl/mcu_controller.sv
// UART debug bridge: decodes 8N1 command frames on srx into MCU command strobes
// and returns a status byte plus optional read data on stx.
module mcu_controller #(
   parameter int CLK_RATE      = 100,
   parameter int BAUD          = 115200,
   parameter int BUSY_TIMEOUT  = 1_000_000,
   parameter int FRAME_TIMEOUT = 20 * ((CLK_RATE * 1_000_000) / BAUD) * 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        srx,
   output logic        stx,
   input  logic [31:0] pc,
   input  logic        mcu_busy,
   input  logic [31:0] d_rd,
   input  logic        error,
   output logic [31:0] d_in,
   output logic [31:0] addr,
   output logic        pause,
   output logic        resume,
   output logic        reset,
   output logic        reg_rd,
   output logic        reg_wr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [3:0]  mem_be,
   output logic        valid
);

   localparam int BIT_CYC  = (CLK_RATE * 1_000_000) / BAUD;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CW       = $clog2(BIT_CYC + 1);
   localparam int FTW      = $clog2(FRAME_TIMEOUT + 1);
   localparam int BTW      = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_CYC - 1);
   localparam logic [FTW-1:0] FT_LAST   = FTW'(FRAME_TIMEOUT - 1);
   localparam logic [BTW-1:0] BT_LAST   = BTW'(BUSY_TIMEOUT - 1);

   localparam logic [7:0] OP_PAUSE  = 8'h01;
   localparam logic [7:0] OP_RESUME = 8'h02;
   localparam logic [7:0] OP_RESET  = 8'h03;
   localparam logic [7:0] OP_RDPC   = 8'h04;
   localparam logic [7:0] OP_REGRD  = 8'h05;
   localparam logic [7:0] OP_REGWR  = 8'h06;
   localparam logic [7:0] OP_MEMRD  = 8'h07;
   localparam logic [7:0] OP_MEMWR  = 8'h08;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_ERR     = 8'h01;
   localparam logic [7:0] ST_TIMEOUT = 8'h02;
   localparam logic [7:0] ST_BADOP   = 8'h03;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [2:0] {C_IDLE, C_RX_ARGS, C_ISSUE, C_WAIT, C_REPLY} ctl_state_t;

   rx_state_t  rx_state,  rx_next;
   tx_state_t  tx_state,  tx_next;
   ctl_state_t ctl_state, ctl_next;

   logic          srx_s1, srx_s2, srx_s3;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_byte;
   logic          rx_tick, rx_half, rx_valid, rx_ferr;

   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [9:0]    tx_shift;
   logic          tx_tick, tx_last, tx_ready, tx_start;
   logic [7:0]    tx_data;

   logic [7:0]     opcode;
   logic [3:0]     arg_need, arg_cnt;
   logic [31:0]    addr_buf, data_buf, addr_nx, din_nx;
   logic [3:0]     be_nx;
   logic [39:0]    reply_buf;
   logic [2:0]     reply_left;
   logic [FTW-1:0] ftimer;
   logic [BTW-1:0] btimer;
   logic           wait_first;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state  <= RX_IDLE;
         tx_state  <= TX_IDLE;
         ctl_state <= C_IDLE;
      end else begin
         rx_state  <= rx_next;
         tx_state  <= tx_next;
         ctl_state <= ctl_next;
      end
   end

   assign rx_tick = (rx_cnt == BIT_LAST);
   assign rx_half = (rx_cnt == HALF_LAST);

   // A start needs a high-to-low transition, so a low line after a framing error cannot retrigger.
   always_comb begin
      rx_next  = rx_state;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      unique case (rx_state)
         RX_IDLE:  if (!srx_s2 && srx_s3) rx_next = RX_START;
         RX_START: if (rx_half) rx_next = srx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP: begin
            if (rx_tick) begin
               rx_next  = RX_IDLE;
               rx_valid = srx_s2;
               rx_ferr  = !srx_s2;
            end
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         srx_s1  <= 1'b1;
         srx_s2  <= 1'b1;
         srx_s3  <= 1'b1;
         rx_cnt  <= '0;
         rx_bit  <= '0;
         rx_byte <= '0;
      end else begin
         srx_s1 <= srx;
         srx_s2 <= srx_s1;
         srx_s3 <= srx_s2;
         if (rx_state == RX_IDLE || rx_next != rx_state || rx_tick)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_START) begin
            rx_bit <= '0;
         end else if (rx_state == RX_DATA && rx_tick) begin
            rx_bit  <= rx_bit + 1'b1;
            rx_byte <= {srx_s2, rx_byte[7:1]};
         end
      end
   end

   assign tx_tick  = (tx_cnt == BIT_LAST);
   assign tx_last  = (tx_state == TX_SEND) && (tx_bit == 4'd9) && tx_tick;
   assign tx_ready = (tx_state == TX_IDLE) || tx_last;
   assign stx      = (tx_state == TX_SEND) ? tx_shift[0] : 1'b1;

   // The last stop-bit cycle also accepts a new byte so replies go out back-to-back.
   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         TX_IDLE: if (tx_start) tx_next = TX_SEND;
         TX_SEND: if (tx_last) tx_next = tx_start ? TX_SEND : TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '1;
      end else if (tx_ready && tx_start) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= {1'b1, tx_data, 1'b0};
      end else if (tx_state == TX_SEND) begin
         if (tx_tick) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= {1'b1, tx_shift[9:1]};
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   // Argument bytes fill addr first, then data; the same value feeds the ISSUE outputs.
   always_comb begin
      addr_nx = '0;
      din_nx  = '0;
      be_nx   = '0;
      if (ctl_state == C_RX_ARGS) begin
         addr_nx = addr_buf;
         din_nx  = data_buf;
         if (arg_cnt < 4'd4)
            addr_nx = {addr_buf[23:0], rx_byte};
         else
            din_nx = {data_buf[23:0], rx_byte};
         if (opcode == OP_MEMRD || opcode == OP_MEMWR)
            be_nx = 4'hF;
      end
   end

   always_comb begin
      ctl_next = ctl_state;
      valid    = 1'b0;
      pause    = 1'b0;
      resume   = 1'b0;
      reset    = 1'b0;
      reg_rd   = 1'b0;
      reg_wr   = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      tx_start = 1'b0;
      tx_data  = reply_buf[39:32];
      unique case (ctl_state)
         C_IDLE: begin
            if (rx_valid) begin
               case (rx_byte)
                  OP_PAUSE, OP_RESUME, OP_RESET:        ctl_next = C_ISSUE;
                  OP_REGRD, OP_REGWR, OP_MEMRD, OP_MEMWR: ctl_next = C_RX_ARGS;
                  default:                              ctl_next = C_REPLY;
               endcase
            end
         end
         C_RX_ARGS: begin
            if (rx_ferr || ftimer == FT_LAST)
               ctl_next = C_IDLE;
            else if (rx_valid && arg_cnt == arg_need - 1'b1)
               ctl_next = C_ISSUE;
         end
         C_ISSUE: begin
            ctl_next = C_WAIT;
            valid    = 1'b1;
            pause    = (opcode == OP_PAUSE);
            resume   = (opcode == OP_RESUME);
            reset    = (opcode == OP_RESET);
            reg_rd   = (opcode == OP_REGRD);
            reg_wr   = (opcode == OP_REGWR);
            mem_rd   = (opcode == OP_MEMRD);
            mem_wr   = (opcode == OP_MEMWR);
         end
         C_WAIT: begin
            if (!wait_first && (!mcu_busy || btimer == BT_LAST))
               ctl_next = C_REPLY;
         end
         C_REPLY: begin
            tx_start = 1'b1;
            if (tx_ready && reply_left == 3'd1)
               ctl_next = C_IDLE;
         end
         default: ctl_next = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr       <= '0;
         d_in       <= '0;
         mem_be     <= '0;
         opcode     <= '0;
         arg_need   <= '0;
         arg_cnt    <= '0;
         addr_buf   <= '0;
         data_buf   <= '0;
         reply_buf  <= '0;
         reply_left <= '0;
         ftimer     <= '0;
         btimer     <= '0;
         wait_first <= 1'b0;
      end else begin
         if (ctl_next == C_ISSUE) begin
            addr   <= addr_nx;
            d_in   <= din_nx;
            mem_be <= be_nx;
         end
         unique case (ctl_state)
            C_IDLE: begin
               if (rx_valid) begin
                  opcode     <= rx_byte;
                  addr_buf   <= '0;
                  data_buf   <= '0;
                  arg_cnt    <= '0;
                  ftimer     <= '0;
                  arg_need   <= (rx_byte == OP_REGWR || rx_byte == OP_MEMWR) ? 4'd8 : 4'd4;
                  reply_buf  <= (rx_byte == OP_RDPC) ? {ST_OK, pc} : {ST_BADOP, 32'h0};
                  reply_left <= (rx_byte == OP_RDPC) ? 3'd5 : 3'd1;
               end
            end
            C_RX_ARGS: begin
               if (rx_valid) begin
                  addr_buf <= addr_nx;
                  data_buf <= din_nx;
                  arg_cnt  <= arg_cnt + 1'b1;
                  ftimer   <= '0;
               end else if (rx_state != RX_IDLE) begin
                  ftimer <= '0;
               end else begin
                  ftimer <= ftimer + 1'b1;
               end
            end
            C_ISSUE: begin
               wait_first <= 1'b1;
               btimer     <= '0;
            end
            C_WAIT: begin
               wait_first <= 1'b0;
               if (!wait_first) begin
                  if (!mcu_busy) begin
                     reply_buf  <= {(error ? ST_ERR : ST_OK), d_rd};
                     reply_left <= (!error && (opcode == OP_REGRD || opcode == OP_MEMRD)) ? 3'd5 : 3'd1;
                  end else if (btimer == BT_LAST) begin
                     reply_buf  <= {ST_TIMEOUT, 32'h0};
                     reply_left <= 3'd1;
                  end else begin
                     btimer <= btimer + 1'b1;
                  end
               end
            end
            C_REPLY: begin
               if (tx_ready) begin
                  reply_buf  <= {reply_buf[31:0], 8'h00};
                  reply_left <= reply_left - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_controller.sv
// Scoreboard bench for mcu_controller: directed command frames in, expected
// strobes and reply bytes queued, independent monitors pop and compare.
module tb_mcu_controller;

   localparam int CLK_RATE      = 100;
   localparam int BAUD          = 10_000_000;
   localparam int BIT_CYC       = 10;
   localparam int BUSY_TIMEOUT  = 300;
   localparam int FRAME_TIMEOUT = 2000;

   localparam logic [6:0] S_PAUSE  = 7'b1000000;
   localparam logic [6:0] S_RESUME = 7'b0100000;
   localparam logic [6:0] S_RESET  = 7'b0010000;
   localparam logic [6:0] S_REGRD  = 7'b0001000;
   localparam logic [6:0] S_REGWR  = 7'b0000100;
   localparam logic [6:0] S_MEMRD  = 7'b0000010;
   localparam logic [6:0] S_MEMWR  = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst, srx, stx, mcu_busy, error;
   logic [31:0] pc, d_rd, d_in, addr;
   logic        pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr, valid;
   logic [3:0]  mem_be;

   typedef struct packed {
      logic [6:0]  strb;
      logic [31:0] addr;
      logic [31:0] din;
      logic [3:0]  be;
   } cmd_t;

   cmd_t       exp_cmd[$];
   logic [7:0] exp_byte[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         valid_seen = 0;
   int         busy_len = 5;
   bit         ignore_tx = 1'b0;

   mcu_controller #(
      .CLK_RATE    (CLK_RATE),
      .BAUD        (BAUD),
      .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .srx(srx), .stx(stx), .pc(pc), .mcu_busy(mcu_busy),
      .d_rd(d_rd), .error(error), .d_in(d_in), .addr(addr), .pause(pause),
      .resume(resume), .reset(reset), .reg_rd(reg_rd), .reg_wr(reg_wr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be), .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_cmd(input logic [6:0] s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      cmd_t c;
      c.strb = s; c.addr = a; c.din = d; c.be = b;
      exp_cmd.push_back(c);
   endtask

   task automatic send_byte(input logic [7:0] b);
      srx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         srx = b[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      srx = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic drain(input string name, input int limit);
      int n = 0;
      while ((exp_byte.size() != 0 || exp_cmd.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({name, "_outstanding"}, 64'(exp_byte.size() + exp_cmd.size()), 64'd0);
      exp_byte.delete();
      exp_cmd.delete();
      repeat (3 * BIT_CYC) @(negedge clk);
   endtask

   // Command monitor: every valid cycle must match the next queued command.
   initial begin
      logic       prev_valid = 1'b0;
      logic [6:0] strb;
      cmd_t       c;
      forever begin
         @(negedge clk);
         strb = {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr};
         if (!rst) begin
            if (valid) begin
               valid_seen++;
               check("valid_one_cycle", 64'(prev_valid), 64'd0);
               if (exp_cmd.size() == 0) begin
                  check("unexpected_valid", 64'(valid), 64'd0);
               end else begin
                  c = exp_cmd.pop_front();
                  check("strobe", 64'(strb), 64'(c.strb));
                  check("addr", 64'(addr), 64'(c.addr));
                  check("d_in", 64'(d_in), 64'(c.din));
                  check("mem_be", 64'(mem_be), 64'(c.be));
               end
            end else if (strb != 7'b0) begin
               check("strobe_without_valid", 64'(strb), 64'd0);
            end
         end
         prev_valid = valid;
      end
   end

   // MCU model: busy for busy_len cycles after each valid.
   initial begin
      mcu_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (valid && !rst) begin
            mcu_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            mcu_busy = 1'b0;
         end
      end
   end

   // UART receiver on stx: each received byte is compared with the reply queue.
   initial begin
      logic [7:0] b;
      logic       stop;
      forever begin
         @(negedge stx);
         repeat (BIT_CYC / 2) @(negedge clk);
         b = '0;
         for (int i = 0; i < 8; i++) begin
            repeat (BIT_CYC) @(negedge clk);
            b[i] = stx;
         end
         repeat (BIT_CYC) @(negedge clk);
         stop = stx;
         if (!ignore_tx) begin
            check("stop_bit", 64'(stop), 64'd1);
            if (exp_byte.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_byte: got %02h, expected no byte", b);
            end else begin
               check("reply_byte", 64'(b), 64'(exp_byte.pop_front()));
            end
         end
      end
   end

   initial begin
      int v0, lows, n;
      rst = 1'b1; srx = 1'b1; pc = '0; d_rd = '0; error = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_stx", 64'(stx), 64'd1);
      check("reset_strobes", 64'({valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr}), 64'd0);
      check("reset_outputs", {addr, d_in} | 64'(mem_be), 64'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // short low glitch must not start a frame
      srx = 1'b0;
      repeat (3) @(negedge clk);
      srx = 1'b1;
      repeat (5 * BIT_CYC) @(negedge clk);

      expect_cmd(S_MEMWR, 32'd4, 32'hDEADBEEF, 4'hF);
      exp_byte.push_back(8'h00);
      busy_len = 20;
      send_byte(8'h08); send_word(32'd4); send_word(32'hDEADBEEF);
      drain("mem_write", 3000);

      busy_len = 5;
      d_rd = 32'hDEADBEEF;
      expect_cmd(S_MEMRD, 32'd4, 32'd0, 4'hF);
      exp_byte.push_back(8'h00); exp_byte.push_back(8'hDE); exp_byte.push_back(8'hAD);
      exp_byte.push_back(8'hBE); exp_byte.push_back(8'hEF);
      send_byte(8'h07); send_word(32'd4);
      drain("mem_read", 3000);

      expect_cmd(S_PAUSE, 32'd0, 32'd0, 4'h0);
      exp_byte.push_back(8'h00);
      send_byte(8'h01);
      drain("pause", 2000);

      v0 = valid_seen;
      pc = 32'h10;
      exp_byte.push_back(8'h00); exp_byte.push_back(8'h00); exp_byte.push_back(8'h00);
      exp_byte.push_back(8'h00); exp_byte.push_back(8'h10);
      send_byte(8'h04);
      drain("read_pc", 3000);
      check("read_pc_no_valid", 64'(valid_seen - v0), 64'd0);

      error = 1'b1;
      expect_cmd(S_RESUME, 32'd0, 32'd0, 4'h0);
      exp_byte.push_back(8'h01);
      send_byte(8'h02);
      drain("resume_error", 2000);
      error = 1'b0;

      expect_cmd(S_RESET, 32'd0, 32'd0, 4'h0);
      exp_byte.push_back(8'h00);
      send_byte(8'h03);
      drain("reset_cmd", 2000);

      busy_len = BUSY_TIMEOUT + 10;
      expect_cmd(S_REGWR, 32'd1, 32'h0000_55AA, 4'h0);
      exp_byte.push_back(8'h02);
      send_byte(8'h06); send_word(32'd1); send_word(32'h0000_55AA);
      drain("busy_timeout", 5000);
      n = 0;
      while (mcu_busy && n < 1000) begin @(negedge clk); n++; end
      busy_len = 5;

      v0 = valid_seen;
      exp_byte.push_back(8'h03);
      send_byte(8'h55);
      drain("bad_opcode", 2000);
      check("bad_opcode_no_valid", 64'(valid_seen - v0), 64'd0);

      v0 = valid_seen;
      lows = 0;
      send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
      for (int i = 0; i < FRAME_TIMEOUT + 500; i++) begin
         @(negedge clk);
         if (!stx) lows++;
      end
      check("frame_timeout_no_valid", 64'(valid_seen - v0), 64'd0);
      check("frame_timeout_no_reply", 64'(lows), 64'd0);
      d_rd = 32'h12345678;
      expect_cmd(S_REGRD, 32'd3, 32'd0, 4'h0);
      exp_byte.push_back(8'h00); exp_byte.push_back(8'h12); exp_byte.push_back(8'h34);
      exp_byte.push_back(8'h56); exp_byte.push_back(8'h78);
      send_byte(8'h05); send_word(32'd3);
      drain("reg_read_after_timeout", 3000);

      // reset asserted while the read-pc reply is on the wire
      ignore_tx = 1'b1;
      pc = 32'hCAFE0010;
      send_byte(8'h04);
      n = 0;
      while (stx && n < 1000) begin @(negedge clk); n++; end
      check("reply_started", 64'(stx), 64'd0);
      repeat (15 * BIT_CYC) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_reply_reset_stx", 64'(stx), 64'd1);
      check("mid_reply_reset_outputs", {addr, d_in} | 64'({valid, mem_be}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 70 * BIT_CYC; i++) begin
         @(negedge clk);
         if (!stx) lows++;
      end
      check("no_bytes_after_reset", 64'(lows), 64'd0);
      ignore_tx = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
